// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// frame state encoding, data width, frame lengths and the parity helper.
package uart_pkg;

    localparam int unsigned DataWidth       = 8;
    // Bit periods per frame: start + 8 data + stop, plus one when parity is on.
    localparam int unsigned FrameBits       = 10;
    localparam int unsigned FrameBitsParity = 11;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uartStateT;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic parityBit(input logic [DataWidth-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter. Counts Oversample-1 down to 0; zero flags the last
// clk cycle of the current bit period. The owner reloads it on every bit boundary.
module uart_bit_timer #(
    parameter int unsigned Oversample = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic reload,
    output logic zero
);

    localparam int unsigned          CntW      = $clog2(Oversample);
    localparam logic [CntW-1:0]      ReloadVal = CntW'(Oversample - 1);

    logic [CntW-1:0] cntQ;

    // Reload on reset or on request, otherwise count down one per cycle.
    always_ff @(posedge clk) begin
        if (reset || reload) begin
            cntQ <= ReloadVal;
        end else begin
            cntQ <= cntQ - CntW'(1);
        end
    end

    assign zero = (cntQ == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 framing with Oversample clk cycles per bit.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned Oversample = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DataWidth-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 out,
    output logic                 done
);

    localparam logic [2:0] LastBit = 3'(DataWidth - 1);

    uartStateT            stateQ, stateD;
    logic [DataWidth-1:0] shiftQ, shiftD;
    logic [2:0]           bitIdxQ, bitIdxD;
    logic                 outQ, outD;
    logic                 bitZero;
    logic                 timerReload;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 parityQ, parityD;
`endif

    // Held in reload while idle so START always begins with a full bit period.
    assign timerReload = (stateQ == StIdle) || bitZero;

    uart_bit_timer #(
        .Oversample (Oversample)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .reload (timerReload),
        .zero   (bitZero)
    );

    // Handshake and end-of-frame pulse; ready in the last STOP cycle makes frames gapless.
    always_comb begin
        ready  = (stateQ == StIdle) || ((stateQ == StStop) && bitZero);
        done   = (stateQ == StStop) && bitZero;
        accept = valid && ready;
    end

    // Next-state, shift register and next serial bit.
    always_comb begin
        stateD  = stateQ;
        shiftD  = shiftQ;
        bitIdxD = bitIdxQ;
`ifdef UART_TX_PARITY_EN
        parityD = parityQ;
`endif

        unique case (stateQ)
            StIdle: begin
                if (accept) begin
                    stateD  = StStart;
                    shiftD  = data;
                    bitIdxD = '0;
`ifdef UART_TX_PARITY_EN
                    parityD = parityBit(data);
`endif
                end
            end
            StStart: begin
                if (bitZero) begin
                    stateD  = StData;
                    bitIdxD = '0;
                end
            end
            StData: begin
                if (bitZero) begin
                    shiftD  = shiftQ >> 1;
                    bitIdxD = bitIdxQ + 3'd1;
                    if (bitIdxQ == LastBit) begin
`ifdef UART_TX_PARITY_EN
                        stateD = StParity;
`else
                        stateD = StStop;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bitZero) begin
                    stateD = StStop;
                end
            end
`endif
            StStop: begin
                if (bitZero) begin
                    if (accept) begin
                        stateD  = StStart;
                        shiftD  = data;
                        bitIdxD = '0;
`ifdef UART_TX_PARITY_EN
                        parityD = parityBit(data);
`endif
                    end else begin
                        stateD = StIdle;
                    end
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase

        // The line register follows the next state so out lines up with stateQ.
        case (stateD)
            StStart:  outD = 1'b0;
            StData:   outD = shiftD[0];
`ifdef UART_TX_PARITY_EN
            StParity: outD = parityD;
`endif
            default:  outD = 1'b1;
        endcase
    end

    // State, shift register and line register; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ  <= StIdle;
            shiftQ  <= '0;
            bitIdxQ <= '0;
            outQ    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parityQ <= 1'b0;
`endif
        end else begin
            stateQ  <= stateD;
            shiftQ  <= shiftD;
            bitIdxQ <= bitIdxD;
            outQ    <= outD;
`ifdef UART_TX_PARITY_EN
            parityQ <= parityD;
`endif
        end
    end

    assign out = outQ;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at Oversample=16. Define UART_TX_PARITY_EN to
// exercise the 8E1 build.
module tb_uart_tx;

    localparam int unsigned Os = 16;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBits = 11;
`else
    localparam int unsigned NBits = 10;
`endif
    localparam int unsigned FrameLen = NBits * Os;

    logic       clk;
    logic       reset;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       out;
    logic       done;

    int vecCnt;
    int errCnt;

    uart_tx #(
        .Oversample (Os)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .out   (out),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at the negedge of the accept cycle (cycle 0); watches cycles 1..FrameLen.
    // At cycle 1 the inputs switch to nextData/nextValid while ready is low.
    task automatic watchFrame(input string tag, input logic [7:0] b, input logic [7:0] nextData,
                              input logic nextValid, output logic [7:0] rxByte,
                              output logic rxErr, output logic rxPar);
        logic [10:0] frm;
        logic [10:0] smp;
        int          bad;
        int          nDone;
        int          doneAt;
        int          k;
`ifdef UART_TX_PARITY_EN
        frm = {1'b1, ^b, b, 1'b0};
`else
        frm = {2'b11, b, 1'b0};
`endif
        smp    = '0;
        bad    = 0;
        nDone  = 0;
        doneAt = 0;
        for (int c = 1; c <= int'(FrameLen); c++) begin
            @(negedge clk);
            if (c == 1) begin
                data  = nextData;
                valid = nextValid;
            end
            k = (c - 1) / Os;
            if (out !== frm[k]) bad++;
            if (done === 1'b1) begin
                nDone++;
                doneAt = c;
            end
            if ((c - 1) % Os == Os / 2) smp[k] = out;
            if (c == int'(FrameLen) / 2) checkEq({tag, ".rdyMid"}, 32'(ready), 32'd0);
            if (c == int'(FrameLen)) checkEq({tag, ".rdyEnd"}, 32'(ready), 32'd1);
        end
        checkEq({tag, ".bits"}, 32'(bad), 32'd0);
        checkEq({tag, ".doneN"}, 32'(nDone), 32'd1);
        checkEq({tag, ".doneAt"}, 32'(doneAt), 32'(FrameLen));
        rxByte = smp[8:1];
        rxErr  = (smp[0] !== 1'b0) || (smp[NBits-1] !== 1'b1);
        rxPar  = smp[9];
    endtask

    task automatic sendFrame(input string tag, input logic [7:0] b, input logic [7:0] nextData,
                             input logic nextValid, output logic [7:0] rxByte,
                             output logic rxErr, output logic rxPar);
        data  = b;
        valid = 1'b1;
        checkEq({tag, ".rdy0"}, 32'(ready), 32'd1);
        watchFrame(tag, b, nextData, nextValid, rxByte, rxErr, rxPar);
    endtask

    logic [7:0] rxByte;
    logic       rxErr;
    logic       rxPar;
    logic [7:0] loopBytes [4];
    int         nDone;
    int         nLow;

    initial begin
        vecCnt = 0;
        errCnt = 0;
        reset  = 1'b1;
        valid  = 1'b0;
        data   = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkEq("rst.out", 32'(out), 32'd1);
        checkEq("rst.ready", 32'(ready), 32'd1);
        checkEq("rst.done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);

        // 0xA5: line 0,1,0,1,0,0,1,0,1,1; done at cycle 160.
        sendFrame("a5", 8'hA5, 8'h00, 1'b0, rxByte, rxErr, rxPar);
        checkEq("a5.rx", 32'(rxByte), 32'hA5);
        checkEq("a5.err", 32'(rxErr), 32'd0);
        repeat (3) @(negedge clk);

        // valid held: 0x00 then 0xFF back to back, no idle gap.
        sendFrame("b2b0", 8'h00, 8'hFF, 1'b1, rxByte, rxErr, rxPar);
        checkEq("b2b0.rx", 32'(rxByte), 32'h00);
        watchFrame("b2b1", 8'hFF, 8'h00, 1'b0, rxByte, rxErr, rxPar);
        checkEq("b2b1.rx", 32'(rxByte), 32'hFF);
        checkEq("b2b1.err", 32'(rxErr), 32'd0);
        repeat (3) @(negedge clk);

        // Reset at cycle 50 of a 0x3C frame.
        data  = 8'h3C;
        valid = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c == 1) valid = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkEq("mid.out", 32'(out), 32'd1);
        checkEq("mid.ready", 32'(ready), 32'd1);
        checkEq("mid.done", 32'(done), 32'd0);
        nDone = 0;
        nLow  = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done !== 1'b0) nDone++;
            if (out !== 1'b1) nLow++;
        end
        checkEq("mid.noDone", 32'(nDone), 32'd0);
        checkEq("mid.idleHigh", 32'(nLow), 32'd0);
        sendFrame("mid3c", 8'h3C, 8'h00, 1'b0, rxByte, rxErr, rxPar);
        checkEq("mid3c.rx", 32'(rxByte), 32'h3C);
        repeat (3) @(negedge clk);

        // Data changes to 0x22 while busy; 0x11 must go out.
        sendFrame("hold", 8'h11, 8'h22, 1'b0, rxByte, rxErr, rxPar);
        checkEq("hold.rx", 32'(rxByte), 32'h11);
        repeat (3) @(negedge clk);

        // Reset wins over a simultaneous accept.
        reset = 1'b1;
        valid = 1'b1;
        data  = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        valid = 1'b0;
        checkEq("prio.out", 32'(out), 32'd1);
        checkEq("prio.ready", 32'(ready), 32'd1);
        nLow = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out !== 1'b1) nLow++;
        end
        checkEq("prio.dropped", 32'(nLow), 32'd0);

        // Loopback through a mid-bit sampling receiver.
        loopBytes[0] = 8'h00;
        loopBytes[1] = 8'h55;
        loopBytes[2] = 8'hFF;
        loopBytes[3] = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            sendFrame("loop", loopBytes[i], 8'h00, 1'b0, rxByte, rxErr, rxPar);
            checkEq("loop.rx", 32'(rxByte), 32'(loopBytes[i]));
            checkEq("loop.err", 32'(rxErr), 32'd0);
            repeat (2) @(negedge clk);
        end

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 has three ones -> 1; 0x03 has two -> 0. Frame 176 cycles.
        sendFrame("par07", 8'h07, 8'h00, 1'b0, rxByte, rxErr, rxPar);
        checkEq("par07.bit", 32'(rxPar), 32'd1);
        checkEq("par07.rx", 32'(rxByte), 32'h07);
        repeat (2) @(negedge clk);
        sendFrame("par03", 8'h03, 8'h00, 1'b0, rxByte, rxErr, rxPar);
        checkEq("par03.bit", 32'(rxPar), 32'd0);
        checkEq("par03.rx", 32'(rxByte), 32'h03);
        repeat (2) @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
